// File: rtl/pipelined_adder.sv
// Carry-chunked pipelined adder: {cout, s} = a + b + cin, one chunk of WIDTH/STAGES bits per stage.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             valid_in,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             valid_out
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned C = (STAGES == 0) ? 1 : WIDTH / STAGES;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be at least 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be divisible by STAGES");
    end

    // Stage k holds operand chunks k..STAGES-1 and the finished sum chunks below k.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned OW = WIDTH - k * C;

        logic [OW-1:0]        op_a;
        logic [OW-1:0]        op_b;
        logic [OW-1:0]        in_a;
        logic [OW-1:0]        in_b;
        logic                 carry;
        logic                 in_carry;
        logic                 vld;
        logic                 in_vld;
        logic [C:0]           add;
        logic [(k+1)*C-1:0]   sum_nx;

        if (k == 0) begin : g_head
            assign in_a     = a;
            assign in_b     = b;
            assign in_carry = cin;
            assign in_vld   = valid_in;
            assign sum_nx   = add[C-1:0];
        end else begin : g_tail
            logic [k*C-1:0] low;

            assign in_a     = g_stage[k-1].op_a[WIDTH-(k-1)*C-1:C];
            assign in_b     = g_stage[k-1].op_b[WIDTH-(k-1)*C-1:C];
            assign in_carry = g_stage[k-1].add[C];
            assign in_vld   = g_stage[k-1].vld;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    low <= '0;
                end else if (in_vld) begin
                    low <= g_stage[k-1].sum_nx;
                end
            end

            assign sum_nx = {add[C-1:0], low};
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                vld   <= 1'b0;
                op_a  <= '0;
                op_b  <= '0;
                carry <= 1'b0;
            end else begin
                vld <= in_vld;
                if (in_vld) begin
                    op_a  <= in_a;
                    op_b  <= in_b;
                    carry <= in_carry;
                end
            end
        end

        always_comb begin
            add = {1'b0, op_a[C-1:0]} + {1'b0, op_b[C-1:0]} + {{C{1'b0}}, carry};
        end
    end

    logic             last_vld;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    assign last_vld  = g_stage[STAGES-1].vld;
    assign last_sum  = g_stage[STAGES-1].sum_nx;
    assign last_cout = g_stage[STAGES-1].add[C];

`ifdef ADDER_OVF_EN
    logic last_ovf;

    // Top operand chunk still carries both operand MSBs, so no separate MSB skew is needed.
    assign last_ovf = (g_stage[STAGES-1].op_a[C-1] == g_stage[STAGES-1].op_b[C-1]) &&
                      (g_stage[STAGES-1].add[C-1] != g_stage[STAGES-1].op_a[C-1]);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            valid_out <= last_vld;
            if (last_vld) begin
                s    <= last_sum;
                cout <= last_cout;
`ifdef ADDER_OVF_EN
                ovf  <= last_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: STAGES=4, 1 and 8 instances share one stimulus stream;
// each instance is checked every cycle against a whole-word reference with its own latency.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         valid_in;

    logic [W-1:0] s_o    [NI];
    logic         cout_o [NI];
    logic         vo     [NI];
`ifdef ADDER_OVF_EN
    logic         ovf_o  [NI];
`endif

    int lat [NI] = '{4, 1, 8};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .cin(cin), .valid_in(valid_in),
        .s(s_o[0]), .cout(cout_o[0]), .valid_out(vo[0])
`ifdef ADDER_OVF_EN
        , .ovf(ovf_o[0])
`endif
    );

    pipelined_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .cin(cin), .valid_in(valid_in),
        .s(s_o[1]), .cout(cout_o[1]), .valid_out(vo[1])
`ifdef ADDER_OVF_EN
        , .ovf(ovf_o[1])
`endif
    );

    pipelined_adder #(.WIDTH(W), .STAGES(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .a(a), .b(b), .cin(cin), .valid_in(valid_in),
        .s(s_o[2]), .cout(cout_o[2]), .valid_out(vo[2])
`ifdef ADDER_OVF_EN
        , .ovf(ovf_o[2])
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [10];

    // One entry per cycle of a stimulus stream.
    logic [W-1:0] st_a   [32];
    logic [W-1:0] st_b   [32];
    logic         st_cin [32];
    logic         st_v   [32];
    logic         st_rst [32];
    logic [W-1:0] st_es  [32];
    logic         st_ec  [32];
    logic         st_eo  [32];

    logic [W-1:0] last_s [NI];
    logic         last_c [NI];
    logic         last_o [NI];

    function automatic logic [W-1:0] z(input logic x);
        return {{(W-1){1'b0}}, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int k, input int t,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d (stages %0d) t=%0d: got %h, expected %h",
                     nm, k, lat[k], t, act, exp);
        end
    endtask

    task automatic set_op(input int t, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input logic ov, input logic orst);
        logic [W:0] r;
        r = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        st_a[t]   = oa;
        st_b[t]   = ob;
        st_cin[t] = oc;
        st_v[t]   = ov;
        st_rst[t] = orst;
        st_es[t]  = r[W-1:0];
        st_ec[t]  = r[W];
        st_eo[t]  = (oa[W-1] == ob[W-1]) && (r[W-1] != oa[W-1]);
    endtask

    // Entry t is sampled at edge t; instance k shows op i after edge i+lat[k]
    // unless a reset is sampled at any edge from i to that output edge.
    task automatic run_stream(input int n);
        for (int t = 0; t < n + 10; t++) begin
            if (t < n) begin
                a        = st_a[t];
                b        = st_b[t];
                cin      = st_cin[t];
                valid_in = st_v[t];
                rstn     = ~st_rst[t];
            end else begin
                a        = '0;
                b        = '0;
                cin      = 1'b0;
                valid_in = 1'b0;
                rstn     = 1'b1;
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                logic ev;
                int   i;
                ev = 1'b0;
                i  = t - lat[k];
                if (t < n && st_rst[t]) begin
                    last_s[k] = '0;
                    last_c[k] = 1'b0;
                    last_o[k] = 1'b0;
                end else if (i >= 0 && i < n && st_v[i]) begin
                    ev = 1'b1;
                    for (int r = i; r <= t && r < n; r++)
                        if (st_rst[r]) ev = 1'b0;
                    if (ev) begin
                        last_s[k] = st_es[i];
                        last_c[k] = st_ec[i];
                        last_o[k] = st_eo[i];
                    end
                end
                chk("valid_out", k, t, z(vo[k]), z(ev));
                chk("s", k, t, s_o[k], last_s[k]);
                chk("cout", k, t, z(cout_o[k]), z(last_c[k]));
`ifdef ADDER_OVF_EN
                chk("ovf", k, t, z(ovf_o[k]), z(last_o[k]));
`endif
            end
        end
        rstn     = 1'b1;
        valid_in = 1'b0;
    endtask

    initial begin
        rstn     = 1'b0;
        valid_in = 1'b1;
        a        = '1;
        b        = '1;
        cin      = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk("reset valid_out", k, -1, z(vo[k]), '0);
            chk("reset s", k, -1, s_o[k], '0);
            chk("reset cout", k, -1, z(cout_o[k]), '0);
`ifdef ADDER_OVF_EN
            chk("reset ovf", k, -1, z(ovf_o[k]), '0);
`endif
            last_s[k] = '0;
            last_c[k] = 1'b0;
            last_o[k] = 1'b0;
        end
        rstn     = 1'b1;
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        tick();

        //             a             b             cin   s             cout  ovf
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[9] = '{32'hFFFFFF00, 32'h00000100, 1'b0, 32'h00000000, 1'b1, 1'b0};

        for (int v = 0; v < 10; v++) begin
            set_op(0, vecs[v].a, vecs[v].b, vecs[v].cin, 1'b1, 1'b0);
            st_es[0] = vecs[v].s;
            st_ec[0] = vecs[v].cout;
            st_eo[0] = vecs[v].ovf;
            run_stream(1);
        end

        // Back-to-back random stream
        for (int i = 0; i < 16; i++)
            set_op(i, $urandom, $urandom, 1'($urandom_range(1)), 1'b1, 1'b0);
        run_stream(16);

        // Every-other-cycle pattern; the bubble carries junk operands
        set_op(0, 32'h12345678, 32'h87654321, 1'b0, 1'b1, 1'b0);
        set_op(1, 32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0, 1'b0);
        set_op(2, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0);
        st_es[0] = 32'h99999999; st_ec[0] = 1'b0; st_eo[0] = 1'b0;
        st_es[2] = 32'h00000000; st_ec[2] = 1'b1; st_eo[2] = 1'b1;
        run_stream(3);

        // Reset two cycles after three ops, with valid_in asserted during reset
        for (int i = 0; i < 3; i++)
            set_op(i, $urandom, $urandom, 1'($urandom_range(1)), 1'b1, 1'b0);
        set_op(3, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
        set_op(4, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 1'b1);
        set_op(5, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
        st_es[5] = 32'h00010000; st_ec[5] = 1'b0; st_eo[5] = 1'b0;
        run_stream(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
